// File: rtl/sad_pipe_pkg.sv
// Shared definitions for the 5-stage SAD pipeline: sequencing states and opcodes.
package sad_pipe_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

endpackage

// File: rtl/mul_wait_counter.sv
// Loadable down-counter tracking the remaining EX cycles of a multiply.
module mul_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - 1'b1;
    end

    // Last stall cycle: the multiply leaves EX at the next edge.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use stalls, multi-cycle multiply hold, branch flush.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_stall_ctrl
    import sad_pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [5:0]        ID_Opcode,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRt,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic              EX_MemRead,
    input  logic              EX_BranchTaken,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IDEX_Bubble,
    output logic              IDEX_Hold,
    output logic              IFID_Flush,
    output logic              IDEX_Flush,
    output logic              MulBusy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       StallCnt
`endif
);

    localparam logic       MUL_MULTI = (MUL_LAT > 1);
    localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);

    state_t state, state_nxt;
    logic   lu;
    logic   cnt_load, cnt_en, cnt_done;

    assign lu = EX_MemRead && (EX_Rt != '0) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    mul_wait_counter #(.W(4)) u_mul_cnt (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (cnt_load),
        .load_val (MUL_LOAD),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IDEX_Hold   = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        MulBusy     = 1'b0;
        case (state)
            ST_RUN: begin
                if (EX_BranchTaken) begin
                    IFID_Flush = 1'b1;
                    IDEX_Flush = 1'b1;
                end else if (lu) begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEX_Bubble = 1'b1;
                end else if ((ID_Opcode == OP_MUL) && MUL_MULTI) begin
                    state_nxt = ST_MUL_WAIT;
                    cnt_load  = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                // EX is owned by the multiply, so a branch cannot resolve here.
                MulBusy   = 1'b1;
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEX_Hold = 1'b1;
                cnt_en    = 1'b1;
                if (cnt_done)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            stall_cnt <= '0;
        else if (!PCWrite && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign StallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MUL_LAT=4 and MUL_LAT=1 instances.
module tb_hazard_stall_ctrl;
    import sad_pipe_pkg::*;

    // Packed output order: {PCWrite,IFIDWrite,Bubble,Hold,IFID_Flush,IDEX_Flush,MulBusy}
    localparam logic [6:0] IDLE  = 7'b1100000;
    localparam logic [6:0] STALL = 7'b0010000;
    localparam logic [6:0] BUSY  = 7'b0001001;
    localparam logic [6:0] FLUSH = 7'b1100110;

    logic       Clk, Rst_n;
    logic [5:0] ID_Opcode;
    logic [4:0] ID_Rs, ID_Rt, EX_Rt;
    logic       ID_UsesRt, EX_MemRead, EX_BranchTaken;

    logic PCWrite, IFIDWrite, IDEX_Bubble, IDEX_Hold, IFID_Flush, IDEX_Flush, MulBusy;
    logic PCWrite1, IFIDWrite1, IDEX_Bubble1, IDEX_Hold1, IFID_Flush1, IDEX_Flush1, MulBusy1;
`ifdef HAZARD_STATS_EN
    logic [15:0] StallCnt, StallCnt1;
`endif

    logic [6:0] outs, outs1;
    assign outs  = {PCWrite, IFIDWrite, IDEX_Bubble, IDEX_Hold, IFID_Flush, IDEX_Flush, MulBusy};
    assign outs1 = {PCWrite1, IFIDWrite1, IDEX_Bubble1, IDEX_Hold1, IFID_Flush1, IDEX_Flush1, MulBusy1};

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.MUL_LAT(4), .REG_AW(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ID_Opcode(ID_Opcode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRt(ID_UsesRt), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
        .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEX_Bubble(IDEX_Bubble), .IDEX_Hold(IDEX_Hold), .IFID_Flush(IFID_Flush),
        .IDEX_Flush(IDEX_Flush), .MulBusy(MulBusy)
`ifdef HAZARD_STATS_EN
        , .StallCnt(StallCnt)
`endif
    );

    hazard_stall_ctrl #(.MUL_LAT(1), .REG_AW(5)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .ID_Opcode(ID_Opcode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRt(ID_UsesRt), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
        .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite1), .IFIDWrite(IFIDWrite1),
        .IDEX_Bubble(IDEX_Bubble1), .IDEX_Hold(IDEX_Hold1), .IFID_Flush(IFID_Flush1),
        .IDEX_Flush(IDEX_Flush1), .MulBusy(MulBusy1)
`ifdef HAZARD_STATS_EN
        , .StallCnt(StallCnt1)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clr_in();
        ID_Opcode      = OP_RTYPE;
        ID_Rs          = '0;
        ID_Rt          = '0;
        ID_UsesRt      = 1'b0;
        EX_Rt          = '0;
        EX_MemRead     = 1'b0;
        EX_BranchTaken = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        clr_in();
        #2;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", outs, IDLE);
        end
        total++;
        if (outs1 !== IDLE) begin
            bad++;
            $display("FAIL reset_idle_lat1 got=%b exp=%b", outs1, IDLE);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        @(posedge Clk); #1;
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        total++;
        if (outs !== STALL) begin
            bad++;
            $display("FAIL lu_rs got=%b exp=%b", outs, STALL);
        end
        @(posedge Clk); #1;
        clr_in();
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL lu_rs_after got=%b exp=%b", outs, IDLE);
        end
        @(posedge Clk); #1;
        EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Rs = 5'd3;
        #1;
        total++;
        if (outs !== STALL) begin
            bad++;
            $display("FAIL lu_rt got=%b exp=%b", outs, STALL);
        end
        @(posedge Clk); #1;
        clr_in();
    endtask

    task automatic test_no_stall();
        @(posedge Clk); #1;
        EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL lu_zero_reg got=%b exp=%b", outs, IDLE);
        end
        @(posedge Clk); #1;
        EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b0; ID_Rs = 5'd3;
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL lu_rt_unused got=%b exp=%b", outs, IDLE);
        end
        @(posedge Clk); #1;
        EX_MemRead = 1'b0; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL lu_not_load got=%b exp=%b", outs, IDLE);
        end
        @(posedge Clk); #1;
        clr_in();
    endtask

    task automatic test_mul();
        logic [6:0] exp1;
        @(posedge Clk); #1;
        ID_Opcode = OP_MUL;
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL mul_issue got=%b exp=%b", outs, IDLE);
        end
        total++;
        if (outs1 !== IDLE) begin
            bad++;
            $display("FAIL mul_issue_lat1 got=%b exp=%b", outs1, IDLE);
        end
        // Branch and load-use inputs during the wait must not disturb the hold.
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            clr_in();
            EX_BranchTaken = (i == 1);
            EX_MemRead     = (i == 2);
            EX_Rt          = 5'd8;
            ID_Rs          = 5'd8;
            exp1 = (i == 0) ? IDLE : ((i == 1) ? FLUSH : STALL);
            #1;
            total++;
            if (outs !== BUSY) begin
                bad++;
                $display("FAIL mul_wait%0d got=%b exp=%b", i, outs, BUSY);
            end
            total++;
            if (outs1 !== exp1) begin
                bad++;
                $display("FAIL mul_lat1_cyc%0d got=%b exp=%b", i, outs1, exp1);
            end
        end
        @(posedge Clk); #1;
        clr_in();
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL mul_done got=%b exp=%b", outs, IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                @(posedge Clk); #1;
            end else begin
                @(posedge Clk); #1;
            end
            ID_Opcode = (c <= 4) ? OP_MUL : OP_RTYPE;
            exp = (c == 0 || c == 4 || c == 8) ? IDLE : BUSY;
            #1;
            total++;
            if (outs !== exp) begin
                bad++;
                $display("FAIL b2b_cyc%0d got=%b exp=%b", c, outs, exp);
            end
        end
        clr_in();
    endtask

    task automatic test_branch();
        @(posedge Clk); #1;
        EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        total++;
        if (outs !== FLUSH) begin
            bad++;
            $display("FAIL br_vs_lu got=%b exp=%b", outs, FLUSH);
        end
        @(posedge Clk); #1;
        clr_in();
        EX_BranchTaken = 1'b1; ID_Opcode = OP_MUL;
        #1;
        total++;
        if (outs !== FLUSH) begin
            bad++;
            $display("FAIL br_vs_mul got=%b exp=%b", outs, FLUSH);
        end
        @(posedge Clk); #1;
        clr_in();
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL br_no_mulwait got=%b exp=%b", outs, IDLE);
        end
    endtask

    task automatic test_reset_mid_mul();
        @(posedge Clk); #1;
        ID_Opcode = OP_MUL;
        @(posedge Clk); #1;
        ID_Opcode = OP_RTYPE;
        @(posedge Clk); #1;
        total++;
        if (outs !== BUSY) begin
            bad++;
            $display("FAIL rst_pre_busy got=%b exp=%b", outs, BUSY);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL rst_async got=%b exp=%b", outs, IDLE);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        ID_Opcode = OP_ADDI;
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL rst_after_addi got=%b exp=%b", outs, IDLE);
        end
        @(posedge Clk); #1;
        clr_in();
        #1;
        total++;
        if (outs !== IDLE) begin
            bad++;
            $display("FAIL rst_no_residual got=%b exp=%b", outs, IDLE);
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        // Counters were cleared by the preceding reset.
        @(posedge Clk); #1;
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        @(posedge Clk); #1;
        clr_in();
        ID_Opcode = OP_MUL;
        @(posedge Clk); #1;
        ID_Opcode = OP_RTYPE;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (StallCnt !== 16'd4) begin
            bad++;
            $display("FAIL stats_count got=%0d exp=4", StallCnt);
        end
        total++;
        if (StallCnt1 !== 16'd1) begin
            bad++;
            $display("FAIL stats_count_lat1 got=%0d exp=1", StallCnt1);
        end
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        @(posedge Clk); #1;
        ID_Opcode = OP_MUL;
        @(posedge Clk); #1;
        ID_Opcode = OP_RTYPE;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (StallCnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL stats_saturate got=%h exp=ffff", StallCnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mul();
        test_back_to_back();
        test_branch();
        test_reset_mid_mul();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
